// File: rtl/debouncer_botoes_if.sv
// Button bus between the raw board keys and the watch FSM.
interface debouncer_botoes_if #(
  parameter int unsigned N_BTN = 3
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;

  // Key side: drives the raw keys, consumes the conditioned events.
  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  // Conditioner side.
  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );
endinterface

// File: rtl/debouncer_botoes.sv
// Push-button conditioner: synchronise, debounce, edge pulses and auto-repeat, one
// identical channel per key.
module debouncer_botoes #(
  parameter int unsigned N_BTN           = 3,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input logic               clk,
  input logic               reset,
  debouncer_botoes_if.slave bus
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  localparam logic [DbW-1:0]  DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RptW-1:0] DelayLoad = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RateLoad  = RptW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRpt} rpt_state_e;

  logic [N_BTN-1:0] level_vec, press_vec, release_vec, repeat_vec;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    logic            sync1_q, sync2_q;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic            level_q, level_d, level_prev_q;
    logic            press_q, release_q, repeat_q;
    logic [RptW-1:0] rpt_cnt_q;
    rpt_state_e      state_q;
    logic            rise;

    // Two-flop synchroniser, normalised so 1 = pressed.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= bus.btn_raw[i] ^ ACTIVE_LOW;
        sync2_q <= sync1_q;
      end
    end

    // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
      level_d  = level_q;
      db_cnt_d = '0;
      if (sync2_q != level_q) begin
        if (db_cnt_q == DbLast) begin
          level_d = ~level_q;
        end else begin
          db_cnt_d = db_cnt_q + DbW'(1);
        end
      end
    end

    // Debounced level plus registered press/release edge pulses.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        db_cnt_q     <= '0;
        level_q      <= 1'b0;
        level_prev_q <= 1'b0;
        press_q      <= 1'b0;
        release_q    <= 1'b0;
      end else begin
        db_cnt_q     <= db_cnt_d;
        level_q      <= level_d;
        level_prev_q <= level_q;
        press_q      <= level_q & ~level_prev_q;
        release_q    <= ~level_q & level_prev_q;
      end
    end

    // Same condition that loads press_q, so the first repeat lands with the press pulse.
    assign rise = level_q & ~level_prev_q;

    // Auto-repeat FSM; checking level_d lets a release win over a coincident expiry.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q   <= StIdle;
        rpt_cnt_q <= '0;
        repeat_q  <= 1'b0;
      end else begin
        repeat_q <= 1'b0;
        unique case (state_q)
          StIdle: begin
            if (rise) begin
              repeat_q  <= 1'b1;
              rpt_cnt_q <= DelayLoad;
              state_q   <= StDelay;
            end
          end
          StDelay, StRpt: begin
            if (!level_d) begin
              rpt_cnt_q <= '0;
              state_q   <= StIdle;
            end else if (rpt_cnt_q == '0) begin
              repeat_q  <= 1'b1;
              rpt_cnt_q <= RateLoad;
              state_q   <= StRpt;
            end else begin
              rpt_cnt_q <= rpt_cnt_q - RptW'(1);
            end
          end
          default: begin
            rpt_cnt_q <= '0;
            state_q   <= StIdle;
          end
        endcase
      end
    end

    assign level_vec[i]   = level_q;
    assign press_vec[i]   = press_q;
    assign release_vec[i] = release_q;
    assign repeat_vec[i]  = repeat_q;
  end

  assign bus.btn_level   = level_vec;
  assign bus.btn_press   = press_vec;
  assign bus.btn_release = release_vec;
  assign bus.btn_repeat  = repeat_vec;

endmodule
